// File: rtl/addsub_pkg.sv
// Opcode encodings shared by the add/subtract front stage and its consumers.
package addsub_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain N-bit ripple-carry adder: {Cout, Sum} = A + B + Cin.
module ripple_carry_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    logic carry;

    always_comb begin
        Sum   = '0;
        carry = Cin;
        for (int i = 0; i < N; i++) begin
            Sum[i] = A[i] ^ B[i] ^ carry;
            carry  = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        Cout = carry;
    end

endmodule

// File: rtl/addsub_flag_stage.sv
// Registered valid/ready stage around the ripple adder producing sum plus NZCV flags,
// with a carry flag kept for multi-word ADC/SBC chains.
module addsub_flag_stage #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         ovf,
    output logic         zero,
    output logic         neg,
    output logic         cflag
);
    import addsub_pkg::*;

    logic [N-1:0] bx;
    logic         cin;
    logic [N-1:0] sum_c;
    logic         cout_c;
    logic         ovf_c;
    logic         zero_c;
    logic         neg_c;
    logic         accept;

    // Subtraction is a + ~b + 1; cout=1 therefore means "no borrow".
    assign bx = op[0] ? ~b : b;

    always_comb begin
        cin = 1'b0;
        case (op)
            OP_ADD:  cin = 1'b0;
            OP_SUB:  cin = 1'b1;
            OP_ADC:  cin = cflag;
            OP_SBC:  cin = cflag;
            default: cin = 1'b0;
        endcase
    end

    ripple_carry_adder #(.N(N)) u_adder (
        .A    (a),
        .B    (bx),
        .Cin  (cin),
        .Sum  (sum_c),
        .Cout (cout_c)
    );

    assign ovf_c  = (a[N-1] == bx[N-1]) && (sum_c[N-1] != a[N-1]);
    assign zero_c = (sum_c == '0);
    assign neg_c  = sum_c[N-1];

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            cflag     <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= sum_c;
            cout      <= cout_c;
            ovf       <= ovf_c;
            zero      <= zero_c;
            neg       <= neg_c;
            cflag     <= cout_c;
        end else if (out_ready) begin
            // Pop without refill: data registers keep their last value.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_addsub_flag_stage.sv
// Directed and exhaustive checks of addsub_flag_stage at N=4 with an independent integer model.
module tb_addsub_flag_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic       neg;
    logic       cflag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } beat_t;

    beat_t      beats[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    addsub_flag_stage #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg),
        .cflag     (cflag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Returns {result[3:0], cout, ovf, zero, neg} using signed/unsigned integer arithmetic.
    function automatic logic [7:0] ref_model(input logic [1:0] o, input logic [3:0] av,
                                             input logic [3:0] bv, input logic cf);
        int ua, ub, sa, sb, u, s, bor, r;
        logic c;
        ua  = int'(av);
        ub  = int'(bv);
        sa  = (ua >= 8) ? ua - 16 : ua;
        sb  = (ub >= 8) ? ub - 16 : ub;
        bor = cf ? 0 : 1;
        case (o)
            2'b00:   begin u = ua + ub;            s = sa + sb;            c = (u > 15);             end
            2'b01:   begin u = ua - ub;            s = sa - sb;            c = (ua >= ub);           end
            2'b10:   begin u = ua + ub + int'(cf); s = sa + sb + int'(cf); c = (u > 15);             end
            default: begin u = ua - ub - bor;      s = sa - sb - bor;      c = (ua >= ub + bor);     end
        endcase
        r = (u + 32) % 16;
        return {r[3:0], c, (s < -8) || (s > 7), (r == 0), r[3]};
    endfunction

    task automatic send(input logic [1:0] o, input logic [3:0] av, input logic [3:0] bv);
        in_valid  = 1'b1;
        op        = o;
        a         = av;
        b         = bv;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    initial begin
        int         idx;
        int         popped;
        int         cyc;
        logic       model_cf;
        logic       do_pop;
        logic       do_acc;
        logic [7:0] e;
        beat_t      bt;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_flags", 32'({result, cout, ovf, zero, neg, cflag}), 0);
        chk("reset_in_ready", 32'(in_ready), 1);

        // 1. ADD 7+9 wraps to zero
        send(2'b00, 4'd7, 4'd9);
        chk("add_valid", 32'(out_valid), 1);
        chk("add_7_9", 32'({result, cout, zero, ovf, neg, cflag}), 32'({4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}));

        // 2. subtraction, borrow and signed overflow
        send(2'b01, 4'd3, 4'd5);
        chk("sub_3_5", 32'({result, cout, neg, ovf}), 32'({4'd14, 1'b0, 1'b1, 1'b0}));
        send(2'b01, 4'd8, 4'd1);
        chk("sub_8_1", 32'({result, ovf, cout}), 32'({4'd7, 1'b1, 1'b1}));

        // 3. multi-word chains
        send(2'b00, 4'd15, 4'd1);
        chk("chain_add", 32'({result, cflag}), 32'({4'd0, 1'b1}));
        send(2'b10, 4'd0, 4'd0);
        chk("chain_adc", 32'({result, cout, cflag}), 32'({4'd1, 1'b0, 1'b0}));
        send(2'b01, 4'd0, 4'd1);
        chk("chain_sub", 32'({result, cflag}), 32'({4'd15, 1'b0}));
        send(2'b11, 4'd0, 4'd0);
        chk("chain_sbc", 32'({result, cout, cflag}), 32'({4'd15, 1'b0, 1'b0}));

        // 4. backpressure freezes everything, then pop+accept back to back
        in_valid = 1'b1; op = 2'b00; a = 4'd1; b = 4'd2; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
            chk("bp_frozen", 32'({out_valid, result, cout, ovf, zero, neg, cflag}),
                32'({1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        chk("bp_pop_accept", 32'({out_valid, result, cout, cflag}), 32'({1'b1, 4'd3, 1'b0, 1'b0}));

        // 5. reset drops an in-flight result
        in_valid = 1'b1; op = 2'b00; a = 4'd15; b = 4'd15; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_held", 32'({out_valid, result}), 32'({1'b1, 4'd3}));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("mid_rst_state", 32'({out_valid, result, cout, ovf, zero, neg, cflag}), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("dropped_stays_gone", 32'(out_valid), 0);
        end

        // 6. exhaustive streaming with random backpressure
        for (int o = 0; o < 4; o++)
            for (int bi = 0; bi < 16; bi++)
                for (int ai = 0; ai < 16; ai++) begin
                    if (o >= 2) begin
                        for (int p = 0; p < 2; p++) begin
                            bt.op = 2'b00;
                            bt.a  = p[0] ? 4'd15 : 4'd0;
                            bt.b  = p[0] ? 4'd1  : 4'd0;
                            beats.push_back(bt);
                            bt.op = 2'(o); bt.a = 4'(ai); bt.b = 4'(bi);
                            beats.push_back(bt);
                        end
                    end else begin
                        bt.op = 2'(o); bt.a = 4'(ai); bt.b = 4'(bi);
                        beats.push_back(bt);
                    end
                end

        model_cf = 1'b0;
        idx      = 0;
        popped   = 0;
        cyc      = 0;
        while ((idx < beats.size() || out_valid) && cyc < 30000) begin
            if (idx < beats.size()) begin
                in_valid = 1'b1;
                op = beats[idx].op; a = beats[idx].a; b = beats[idx].b;
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            do_pop = out_valid && out_ready;
            do_acc = in_valid && in_ready;
            if (do_pop) begin
                if (exp_q.size() == 0) begin
                    chk("stream_spurious_pop", 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_result", 32'({result, cout, ovf, zero, neg}), 32'(e));
                end
                popped++;
            end
            if (do_acc) begin
                e = ref_model(op, a, b, model_cf);
                model_cf = e[3];
                exp_q.push_back(e);
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_no_timeout", 32'(cyc < 30000), 1);
        chk("stream_accepted", 32'(idx), 32'(beats.size()));
        chk("stream_popped", 32'(popped), 32'(beats.size()));
        chk("stream_queue_empty", 32'(exp_q.size()), 0);
        chk("stream_cflag", 32'(cflag), 32'(model_cf));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
